// File: rtl/mem_rd_ctrl_if.sv
// Request/response bundle between a load requester, mem_rd_ctrl and a word-wide memory.
// Signal names match the original flat port list so the integration keeps the same meaning.
interface mem_rd_ctrl_if;
    logic        start;
    logic [15:0] addr;
    logic        byte_ld;
    logic        sign_ext;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;

    modport slave (
        input  start, addr, byte_ld, sign_ext, mem_ack, mem_data,
        output mem_req, mem_addr, busy, done, err, rdata
    );

    modport master (
        output start, addr, byte_ld, sign_ext, mem_ack, mem_data,
        input  mem_req, mem_addr, busy, done, err, rdata
    );
endinterface

// File: rtl/mem_rd_ctrl.sv
// Single-outstanding load controller: issues a word read and formats the halfword or byte result.
// All outputs are registered; a missing acknowledge aborts the load after TIMEOUT request cycles.
module mem_rd_ctrl #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_rd_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        a0_q;
    logic        byte_q;
    logic        sext_q;
    logic        mem_req_q;
    logic [14:0] mem_addr_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;
    logic [7:0]  sel_byte;

    // Lane select and extension use the attributes latched at start, not the live inputs.
    always_comb begin
        sel_byte = a0_q ? bus.mem_data[15:8] : bus.mem_data[7:0];
        rdata_d  = bus.mem_data;
        if (byte_q) begin
            rdata_d = {{8{sext_q & sel_byte[7]}}, sel_byte};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a0_q       <= 1'b0;
            byte_q     <= 1'b0;
            sext_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= REQ;
                        a0_q       <= bus.addr[0];
                        byte_q     <= bus.byte_ld;
                        sext_q     <= bus.sign_ext;
                        mem_addr_q <= bus.addr[15:1];
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                REQ: begin
                    // Acknowledge is tested first so it wins on the final timeout cycle.
                    if (bus.mem_ack) begin
                        state_q   <= DONE;
                        rdata_q   <= rdata_d;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ERR;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Scoreboard bench for mem_rd_ctrl: stimulus queues the expected completion, a monitor checks each pulse.
module tb_mem_rd_ctrl;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_rd_ctrl_if bus ();

    mem_rd_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (bus.done || bus.err)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse_sb_size", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {30'd0, bus.err, bus.done}, e.is_err ? 32'd2 : 32'd1);
                check("pulse_rdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
            end
        end
    end

    // Called at a falling edge; ack_cyc = 0 means never acknowledge (timeout expected).
    task automatic load(input logic [15:0] a, input logic bl, input logic se,
                        input logic [15:0] md, input int unsigned ack_cyc,
                        input logic poke_start, input logic [15:0] exp_rd, input string tag);
        int unsigned last;
        int unsigned req_cycles;
        last       = (ack_cyc == 0) ? TO : ack_cyc;
        req_cycles = 0;
        bus.start    = 1'b1;
        bus.addr     = a;
        bus.byte_ld  = bl;
        bus.sign_ext = se;
        sb.push_back(exp_t'{is_err: (ack_cyc == 0), rdata: exp_rd});
        @(negedge clk);
        bus.start = 1'b0;
        bus.addr  = 16'hFFFF;
        for (int unsigned c = 1; c <= last; c++) begin
            if (bus.mem_req) req_cycles++;
            check({tag, "_mem_addr"}, {17'd0, bus.mem_addr}, {17'd0, a[15:1]});
            check({tag, "_busy_req"}, {31'd0, bus.busy}, 32'd1);
            if (poke_start && c == 2) begin
                bus.start = 1'b1;
                bus.addr  = 16'h0000;
            end
            if (c == ack_cyc) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = md;
            end
            @(negedge clk);
            bus.start    = 1'b0;
            bus.mem_ack  = 1'b0;
            bus.mem_data = 16'h5A5A;
        end
        check({tag, "_req_cycles"}, req_cycles, last);
        check({tag, "_req_dropped"}, {31'd0, bus.mem_req}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_idle_pulses"}, {30'd0, bus.err, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.addr     = '0;
        bus.byte_ld  = 1'b0;
        bus.sign_ext = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;

        repeat (2) @(negedge clk);
        check("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_addr", {17'd0, bus.mem_addr}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy}, 32'd0);
        check("rst_pulses",   {30'd0, bus.err, bus.done}, 32'd0);
        check("rst_rdata",    {16'd0, bus.rdata}, 32'd0);

        rst = 1'b1;
        load(16'h0124, 1'b0, 1'b0, 16'hBEEF, 1, 1'b0, 16'hBEEF, "hw");
        load(16'h0125, 1'b0, 1'b1, 16'hCAFE, 1, 1'b0, 16'hCAFE, "hw_odd");
        load(16'h0007, 1'b1, 1'b1, 16'h80FF, 1, 1'b0, 16'hFF80, "byte_hi_sx");
        load(16'h0007, 1'b1, 1'b0, 16'h80FF, 1, 1'b0, 16'h0080, "byte_hi_zx");
        load(16'h0010, 1'b1, 1'b1, 16'h1234, 2, 1'b0, 16'h0034, "byte_lo_pos");
        load(16'h0010, 1'b1, 1'b1, 16'h12F0, 1, 1'b0, 16'hFFF0, "byte_lo_neg");
        load(16'h0200, 1'b0, 1'b0, 16'h9999, 0, 1'b0, 16'hFFF0, "timeout");
        load(16'h0202, 1'b0, 1'b0, 16'h7777, 8, 1'b0, 16'h7777, "ack_last");
        load(16'h0300, 1'b0, 1'b0, 16'h1357, 6, 1'b1, 16'h1357, "backpressure");

        // Abort a load in its second request cycle; nothing is queued for it.
        bus.start   = 1'b1;
        bus.addr    = 16'h0400;
        bus.byte_ld = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_req_active", {31'd0, bus.mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("abort_busy",    {31'd0, bus.busy}, 32'd0);
        check("abort_rdata",   {16'd0, bus.rdata}, 32'd0);
        check("abort_pulses",  {30'd0, bus.err, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        load(16'h0403, 1'b1, 1'b0, 16'hAB00, 1, 1'b0, 16'h00AB, "after_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
